// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and the data (load/store) port.
// Latency: a request seen in IDLE raises m_req the next cycle; x_valid follows in the cycle m_ready is seen.
// Backpressure: requesters stall until x_valid; data has fixed priority over fetch; the watchdog aborts hung accesses.
module unified_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   // instruction fetch port
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          i_flush,
   output logic          i_valid,
   output logic [DW-1:0] i_rdata,
   output logic          stall_f,
   // data port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          stall_m,
   // memory side
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ready,
   output logic          bus_err
);

   // Watchdog counter only needs to reach TIMEOUT-1.
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WLIM = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [WW-1:0] wdog;
   logic          drop;
   logic          busy;
   logic          timeout_hit;
   logic          done;
   logic          abort;
   logic          grant_d;
   logic          grant_i;

   assign busy        = (state != IDLE);
   // A zero TIMEOUT disables the watchdog entirely.
   assign timeout_hit = (TIMEOUT > 0) && (wdog == WLIM);
   // m_ready takes precedence over a simultaneous timeout.
   assign done        = busy & (m_ready | timeout_hit);
   assign abort       = busy & ~m_ready & timeout_hit;
   // Fixed priority: data wins; a flush blocks the fetch grant in the same cycle.
   assign grant_d     = (state == IDLE) & d_req;
   assign grant_i     = (state == IDLE) & ~d_req & i_req & ~i_flush;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection: arbitrate in IDLE, return to IDLE on completion or abort.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt = BUSY_D;
            end else if (grant_i) begin
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Completion, read data and stall outputs; an aborted access returns zero data.
   always_comb begin
      i_valid = 1'b0;
      d_valid = 1'b0;
      i_rdata = m_ready ? m_rdata : '0;
      d_rdata = m_ready ? m_rdata : '0;
      if (state == BUSY_I) begin
         i_valid = done & ~drop & ~i_flush;
      end
      if (state == BUSY_D) begin
         d_valid = done;
      end
      stall_f = i_req & ~i_valid & ~i_flush;
      stall_m = d_req & ~d_valid;
   end

   // Memory request registers, watchdog, flush-drop flag and sticky bus error.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         bus_err <= 1'b0;
         wdog    <= '0;
         drop    <= 1'b0;
      end else begin
         if (grant_d) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
         end else if (grant_i) begin
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= i_addr;
         end
         if (busy) begin
            if (done) begin
               m_req <= 1'b0;
               wdog  <= '0;
               drop  <= 1'b0;
               if (abort) begin
                  bus_err <= 1'b1;
               end
            end else begin
               // Outputs held stable; only the watchdog advances while waiting.
               wdog <= wdog + 1'b1;
               if ((state == BUSY_I) && i_flush) begin
                  drop <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus hand-built watchdog and reset sequences.
// Each vector drives inputs just after a rising edge and checks outputs on the following falling edge.
// Memory side is driven directly by the vectors, so memory wait states are fully scripted.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_flush;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        stall_f;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        stall_m;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ready;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_valid(i_valid), .i_rdata(i_rdata), .stall_f(stall_f),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .stall_m(stall_m),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready), .bus_err(bus_err)
   );

   // ctl = {i_valid, d_valid, stall_f, stall_m, m_req, bus_err}
   typedef struct {
      bit          rst;
      bit          ir;
      logic [31:0] ia;
      bit          fl;
      bit          dr;
      bit          dw;
      logic [31:0] da;
      logic [31:0] dwd;
      bit          mry;
      logic [31:0] mrd;
      logic [5:0]  ctl;
      bit          chm;
      bit          we;
      logic [31:0] ma;
      logic [31:0] mwd;
      bit          chr;
      logic [31:0] rd;
   } vec_t;

   function automatic vec_t v(bit rst, bit ir, logic [31:0] ia, bit fl, bit dr, bit dw,
                              logic [31:0] da, logic [31:0] dwd, bit mry, logic [31:0] mrd,
                              logic [5:0] ctl, bit chm, bit we, logic [31:0] ma,
                              logic [31:0] mwd, bit chr, logic [31:0] rd);
      vec_t t;
      t.rst = rst; t.ir = ir; t.ia = ia; t.fl = fl; t.dr = dr; t.dw = dw;
      t.da = da; t.dwd = dwd; t.mry = mry; t.mrd = mrd;
      t.ctl = ctl; t.chm = chm; t.we = we; t.ma = ma; t.mwd = mwd; t.chr = chr; t.rd = rd;
      return t;
   endfunction

   function automatic vec_t idle_row(logic [5:0] ctl);
      return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Called just after a rising edge; leaves just after the next rising edge.
   task automatic run_vec(input vec_t t, input string tag);
      reset   = t.rst;
      i_req   = t.ir;
      i_addr  = t.ia;
      i_flush = t.fl;
      d_req   = t.dr;
      d_we    = t.dw;
      d_addr  = t.da;
      d_wdata = t.dwd;
      m_ready = t.mry;
      m_rdata = t.mrd;
      @(negedge clk);
      check({tag, " ctl{iv,dv,sf,sm,mreq,err}"},
            32'({i_valid, d_valid, stall_f, stall_m, m_req, bus_err}), 32'(t.ctl));
      if (t.chm) begin
         check({tag, " m_we"}, 32'(m_we), 32'(t.we));
         check({tag, " m_addr"}, m_addr, t.ma);
         if (t.we) check({tag, " m_wdata"}, m_wdata, t.mwd);
      end
      if (t.chr) begin
         if (t.ctl[5]) check({tag, " i_rdata"}, i_rdata, t.rd);
         else          check({tag, " d_rdata"}, d_rdata, t.rd);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      // ---------------- vector table ----------------
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 0, 0, 0));          // reset state
      // single fetch, zero-wait memory
      tbl.push_back(v(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h40, 0, 0, 0, 0, 0, 1, 'h20020005, 6'b100010, 1, 0, 'h40, 0, 1, 'h20020005));
      tbl.push_back(idle_row(6'b000000));
      // simultaneous fetch + store: store first, bubble, then fetch
      tbl.push_back(v(0, 1, 'h44, 0, 1, 1, 84, 7, 0, 0, 6'b001100, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h44, 0, 1, 1, 84, 7, 1, 'hBAD, 6'b011010, 1, 1, 84, 7, 0, 0));
      tbl.push_back(v(0, 1, 'h44, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h44, 0, 0, 0, 0, 0, 1, 'hAAAA5555, 6'b100010, 1, 0, 'h44, 0, 1, 'hAAAA5555));
      tbl.push_back(idle_row(6'b000000));
      // load with three wait cycles
      tbl.push_back(v(0, 0, 0, 0, 1, 0, 80, 0, 0, 0, 6'b000100, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(v(0, 0, 0, 0, 1, 0, 80, 0, 0, 'hDEAD, 6'b000110, 1, 0, 80, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 0, 80, 0, 1, 'h1234, 6'b010010, 1, 0, 80, 0, 1, 'h1234));
      tbl.push_back(idle_row(6'b000000));
      // flush during a two-wait fetch: no i_valid, access runs to m_ready
      tbl.push_back(v(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h100, 1, 0, 0, 0, 0, 0, 0, 6'b000010, 1, 0, 'h100, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 1, 0, 'h100, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h5A5A, 6'b000010, 1, 0, 'h100, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h200, 0, 0, 0, 0, 0, 1, 'h77, 6'b100010, 1, 0, 'h200, 0, 1, 'h77));
      tbl.push_back(idle_row(6'b000000));
      // flush in IDLE blocks that cycle's grant
      tbl.push_back(v(0, 1, 'h300, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h300, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h300, 0, 0, 0, 0, 0, 1, 'h99, 6'b100010, 1, 0, 'h300, 0, 1, 'h99));
      tbl.push_back(idle_row(6'b000000));
      // flush has no effect on a data access
      tbl.push_back(v(0, 0, 0, 0, 1, 0, 'h10, 0, 0, 0, 6'b000100, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 0, 'h10, 0, 1, 'h42, 6'b010010, 1, 0, 'h10, 0, 1, 'h42));
      tbl.push_back(idle_row(6'b000000));
      // flush in the m_ready cycle of a fetch suppresses i_valid
      tbl.push_back(v(0, 1, 'h500, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 'h500, 1, 0, 0, 0, 0, 1, 'h66, 6'b000010, 1, 0, 'h500, 0, 0, 0));
      tbl.push_back(idle_row(6'b000000));

      // ---------------- reset ----------------
      reset = 1'b1; i_req = 0; i_addr = 0; i_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; m_ready = 0; m_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset m_wdata", m_wdata, 32'h0);
      @(posedge clk);
      #1;

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("row%0d", i));

      // ---------------- m_ready on the timeout cycle wins ----------------
      run_vec(v(0, 0, 0, 0, 1, 0, 'h64, 0, 0, 0, 6'b000100, 0, 0, 0, 0, 0, 0), "tie idle");
      for (int k = 1; k <= 15; k++)
         run_vec(v(0, 0, 0, 0, 1, 0, 'h64, 0, 0, 0, 6'b000110, 1, 0, 'h64, 0, 0, 0),
                 $sformatf("tie wait%0d", k));
      run_vec(v(0, 0, 0, 0, 1, 0, 'h64, 0, 1, 'hCAFE, 6'b010010, 1, 0, 'h64, 0, 1, 'hCAFE), "tie done");
      run_vec(idle_row(6'b000000), "tie after");

      // ---------------- watchdog abort ----------------
      run_vec(v(0, 0, 0, 0, 1, 0, 'h60, 0, 0, 0, 6'b000100, 0, 0, 0, 0, 0, 0), "wd idle");
      for (int k = 1; k <= 15; k++)
         run_vec(v(0, 0, 0, 0, 1, 0, 'h60, 0, 0, 'hFFFFFFFF, 6'b000110, 1, 0, 'h60, 0, 0, 0),
                 $sformatf("wd wait%0d", k));
      run_vec(v(0, 0, 0, 0, 1, 0, 'h60, 0, 0, 'hFFFFFFFF, 6'b010010, 1, 0, 'h60, 0, 1, 0), "wd abort");
      run_vec(idle_row(6'b000001), "wd after");
      run_vec(v(0, 1, 'h700, 0, 0, 0, 0, 0, 0, 0, 6'b001001, 0, 0, 0, 0, 0, 0), "wd fetch idle");
      run_vec(v(0, 1, 'h700, 0, 0, 0, 0, 0, 1, 'h11, 6'b100011, 1, 0, 'h700, 0, 1, 'h11), "wd fetch");
      run_vec(idle_row(6'b000001), "wd sticky");

      // ---------------- reset during BUSY_D ----------------
      run_vec(v(0, 0, 0, 0, 1, 1, 'h88, 5, 0, 0, 6'b000101, 0, 0, 0, 0, 0, 0), "rst idle");
      run_vec(v(1, 0, 0, 0, 1, 1, 'h88, 5, 0, 0, 6'b000111, 1, 1, 'h88, 5, 0, 0), "rst busy");
      run_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 0, 0, 0), "rst after");
      run_vec(v(0, 1, 'h900, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0, 0), "rst fetch idle");
      run_vec(v(0, 1, 'h900, 0, 0, 0, 0, 0, 1, 'h33, 6'b100010, 1, 0, 'h900, 0, 1, 'h33), "rst fetch");
      run_vec(idle_row(6'b000000), "rst end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
